button_debounce_dir: RTL

//   Parametrised front end for the board push-buttons (PacMan up/down/left/right and extras).
//   Per channel: 2-FF synchroniser, counter debounce, one-cycle press/release pulses, optional auto-repeat.

---
 rtl/button_debounce_dir.sv | 122 ++++++++++++
 1 files changed

// File: rtl/button_debounce_dir.sv
// Push-button front end: per-channel 2-FF synchroniser, counter debounce, press/release/repeat
// pulses, and a tracker of the most recently pressed channel for the movement logic.
module button_debounce_dir #(
  parameter int NUM_BTN         = 4,
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 0,
  parameter int IDX_W           = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_rpt,
  output logic [IDX_W-1:0]   last_idx,
  output logic               last_valid
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

  logic [NUM_BTN-1:0] r_s1;
  logic [NUM_BTN-1:0] r_s2;
  logic [NUM_BTN-1:0] r_level;
  logic [NUM_BTN-1:0] r_press;
  logic [NUM_BTN-1:0] r_release;
  logic [NUM_BTN-1:0] r_rpt;
  logic [CNT_W-1:0]   r_cnt  [NUM_BTN];
  logic [CNT_W-1:0]   r_rcnt [NUM_BTN];
  logic [IDX_W-1:0]   r_last_idx;
  logic               r_last_valid;

  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_fall;
  logic [IDX_W-1:0]   w_low_idx;
  logic               w_last_rel;

  // Level flips on the cycle the counter has seen DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    w_rise     = '0;
    w_fall     = '0;
    w_low_idx  = '0;
    w_last_rel = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_rise[i] = r_s2[i] & ~r_level[i] & (r_cnt[i] == DB_LAST);
      w_fall[i] = ~r_s2[i] & r_level[i] & (r_cnt[i] == DB_LAST);
    end
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (w_rise[i]) w_low_idx = IDX_W'(i);
    end
    for (int i = 0; i < NUM_BTN; i++) begin
      if (w_fall[i] && (r_last_idx == IDX_W'(i))) w_last_rel = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1         <= '0;
      r_s2         <= '0;
      r_level      <= '0;
      r_press      <= '0;
      r_release    <= '0;
      r_rpt        <= '0;
      r_last_idx   <= '0;
      r_last_valid <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_cnt[i]  <= '0;
        r_rcnt[i] <= '0;
      end
    end else begin
      r_s1      <= btn_in;
      r_s2      <= r_s1;
      r_press   <= w_rise;
      r_release <= w_fall;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (r_s2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_level[i] <= r_s2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end

        // Release takes priority over a coinciding repeat tick.
        if (REPEAT_CYCLES == 0) begin
          r_rpt[i]  <= w_rise[i];
          r_rcnt[i] <= '0;
        end else if (w_fall[i] || (!r_level[i] && !w_rise[i])) begin
          r_rpt[i]  <= 1'b0;
          r_rcnt[i] <= '0;
        end else if (w_rise[i]) begin
          r_rpt[i]  <= 1'b1;
          r_rcnt[i] <= '0;
        end else if (r_rcnt[i] == RP_LAST) begin
          r_rpt[i]  <= 1'b1;
          r_rcnt[i] <= '0;
        end else begin
          r_rpt[i]  <= 1'b0;
          r_rcnt[i] <= r_rcnt[i] + CNT_W'(1);
        end
      end

      if (|w_rise) begin
        r_last_idx   <= w_low_idx;
        r_last_valid <= 1'b1;
      end else if (w_last_rel) begin
        r_last_valid <= 1'b0;
      end
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign btn_rpt     = r_rpt;
  assign last_idx    = r_last_idx;
  assign last_valid  = r_last_valid;

endmodule
